// File: rtl/if_id_stage_if.sv
// if_id_stage_if: fetch/decode signal bundle around the IF/ID pipeline register
interface if_id_stage_if;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_valid;
    logic        stall_pc;
    logic        stall_if_id;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        bubble;
    modport master (
        output im_addr, id_inst, id_pc, id_valid, bubble,
        input  im_rdata, im_valid, stall_pc, stall_if_id, branch_taken, branch_target
    );
    modport slave (
        input  im_addr, id_inst, id_pc, id_valid, bubble,
        output im_rdata, im_valid, stall_pc, stall_if_id, branch_taken, branch_target
    );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: PC register, instruction fetch and IF/ID register with bounded stall hold
module if_id_stage #(
    parameter logic [31:0] PC_RESET     = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h6400_0009,
    parameter int          STALL_CYCLES = 1
) (
    input logic            clk,
    input logic            rst,
    if_id_stage_if.master  bus
);
    typedef enum logic {RUN, HOLD} state_t;
    localparam logic [1:0] CNT_INIT = 2'(STALL_CYCLES >= 2 ? STALL_CYCLES - 2 : 0);
    state_t      state, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, ipc_q, ipc_d;
    logic        valid_q, valid_d, served_q, served_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        eff_stall;
    // a stall applies once per valid instruction and never against a redirect
    assign eff_stall = (bus.stall_pc | bus.stall_if_id) & valid_q & ~served_q & ~bus.branch_taken;
    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            pc_q     <= PC_RESET;
            inst_q   <= NOP_INST;
            ipc_q    <= 32'h0;
            valid_q  <= 1'b0;
            served_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            state    <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            served_q <= served_d;
            cnt_q    <= cnt_d;
        end
    end
    // next state: redirect beats hold, hold beats stall, otherwise advance
    always_comb begin
        state_d  = state;
        pc_d     = pc_q;
        inst_d   = inst_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        served_d = served_q;
        cnt_d    = cnt_q;
        if (bus.branch_taken) begin
            pc_d     = bus.branch_target & ~32'd3;
            inst_d   = NOP_INST;
            valid_d  = 1'b0;
            served_d = 1'b0;
            state_d  = RUN;
        end else if (state == HOLD) begin
            if (cnt_q == 2'd0) begin
                served_d = 1'b1;
                state_d  = RUN;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (eff_stall) begin
            if (STALL_CYCLES == 1) begin
                served_d = 1'b1;
            end else begin
                state_d = HOLD;
                cnt_d   = CNT_INIT;
            end
        end else begin
            served_d = 1'b0;
            if (bus.im_valid) begin
                inst_d  = bus.im_rdata;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
            end else begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
        end
    end
    // outputs: registered values plus the combinational bubble flag
    always_comb begin
        bus.im_addr  = pc_q;
        bus.id_inst  = inst_q;
        bus.id_pc    = ipc_q;
        bus.id_valid = valid_q;
        bus.bubble   = ((state == HOLD) & ~bus.branch_taken) | ((state == RUN) & eff_stall);
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench running STALL_CYCLES=1 and =3 instances side by side
module tb_if_id_stage;
    localparam logic [31:0] NOP = 32'h6400_0009;
    typedef struct packed {
        logic        bubble;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imv = 1'b0, sp = 1'b0, si = 1'b0, br = 1'b0;
    logic [31:0] rdata = 32'h0, tgt = 32'h0;
    int          checks = 0, errors = 0;
    obs_t        q[2][$];

    logic [31:0] m_pc[2], m_inst[2], m_ipc[2];
    logic        m_val[2], m_srv[2];
    int          m_hold[2];
    int          sc[2] = '{1, 3};

    always #5 clk = ~clk;

    if_id_stage_if b1();
    if_id_stage_if b3();
    assign b1.im_rdata = rdata;  assign b3.im_rdata = rdata;
    assign b1.im_valid = imv;    assign b3.im_valid = imv;
    assign b1.stall_pc = sp;     assign b3.stall_pc = sp;
    assign b1.stall_if_id = si;  assign b3.stall_if_id = si;
    assign b1.branch_taken = br; assign b3.branch_taken = br;
    assign b1.branch_target = tgt; assign b3.branch_target = tgt;

    if_id_stage #(.PC_RESET(32'h0), .NOP_INST(NOP), .STALL_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    if_id_stage #(.PC_RESET(32'h0), .NOP_INST(NOP), .STALL_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic model_reset(input int k);
        m_pc[k] = 32'h0; m_inst[k] = NOP; m_ipc[k] = 32'h0;
        m_val[k] = 1'b0; m_srv[k] = 1'b0; m_hold[k] = 0;
    endtask

    // Reference: an instruction in ID owes sc[k] bubbles in total; m_hold counts the ones still owed after the first.
    task automatic model_step(input int k);
        obs_t e;
        logic stall;
        stall = (sp | si) & m_val[k] & ~m_srv[k];
        e.addr = m_pc[k]; e.inst = m_inst[k]; e.pc = m_ipc[k]; e.valid = m_val[k];
        e.bubble = br ? 1'b0 : (m_hold[k] > 0 ? 1'b1 : stall);
        q[k].push_back(e);
        if (!rst) model_reset(k);
        else if (br) begin
            m_pc[k] = {tgt[31:2], 2'b00}; m_inst[k] = NOP; m_val[k] = 1'b0;
            m_srv[k] = 1'b0; m_hold[k] = 0;
        end else if (m_hold[k] > 0) begin
            m_hold[k]--;
            if (m_hold[k] == 0) m_srv[k] = 1'b1;
        end else if (stall) begin
            if (sc[k] == 1) m_srv[k] = 1'b1;
            else m_hold[k] = sc[k] - 1;
        end else begin
            m_srv[k] = 1'b0;
            if (imv) begin
                m_inst[k] = rdata; m_ipc[k] = m_pc[k]; m_val[k] = 1'b1; m_pc[k] = m_pc[k] + 32'd4;
            end else begin
                m_inst[k] = NOP; m_val[k] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic p, input logic s,
                        input logic b, input logic [31:0] t);
        @(negedge clk);
        rst = r; imv = v; sp = p; si = s; br = b; tgt = t; rdata = $urandom;
        #1;
        model_step(0);
        model_step(1);
    endtask

    task automatic cmp(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got bubble=%b addr=%h inst=%h pc=%h valid=%b, expected bubble=%b addr=%h inst=%h pc=%h valid=%b",
                     name, act.bubble, act.addr, act.inst, act.pc, act.valid,
                     exp.bubble, exp.addr, exp.inst, exp.pc, exp.valid);
        end
    endtask

    // monitor: every cycle the DUTs present outputs, pop the expectation and compare
    initial forever begin
        @(negedge clk);
        #2;
        if (q[0].size() != 0) cmp("stall1", {b1.bubble, b1.im_addr, b1.id_inst, b1.id_pc, b1.id_valid}, q[0].pop_front());
        if (q[1].size() != 0) cmp("stall3", {b3.bubble, b3.im_addr, b3.id_inst, b3.id_pc, b3.id_valid}, q[1].pop_front());
    end

    initial begin
        @(posedge clk);
        model_reset(0);
        model_reset(1);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        repeat (4) step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        repeat (5) step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 1, 1, 32'h0000_0103);
        repeat (2) step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 32'h0000_0020);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        repeat (2) step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 32'hFFFF_FFFC);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, t);
        end
        @(negedge clk);
        #3;
        checks++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q[0].size(), q[1].size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
